// File: rtl/pagerank_noc_arbiter.sv
// -----------------------------------------------------------------------------
// pagerank_noc_arbiter
//
// Shares the single page-value query path between the PageRank ant blocks.
// One requesting ant is granted at a time, round-robin from ptr. Its page id
// is presented to the owning ant, the owner's combinational reply is
// captured, and {value, page_id} is returned to the requester.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   req_valid    per-ant request strobe
//   req_page     flattened page ids, ant i at [i*PW +: PW]
//   query        page id driven to the owning ant (QUERY and REPLY)
//   query_valid  one-hot owner select, zero when idle or out of range
//   reply_in     flattened owner replies, ant i at [i*WIDTH +: WIDTH]
//   response     registered {value, page_id}
//   resp_valid   one-hot, one-cycle strobe to the granted ant
//   busy         high whenever the FSM is not in IDLE
//   err          sticky out-of-range page flag
//   xfer_count   completed transactions, wraps at 16 bits
//   dbg_state    current FSM state (0 IDLE, 1 QUERY, 2 REPLY, 3 RESP)
//
// Handshake: an ant raises req_valid[i] with req_page held stable and keeps
// it high until it sees resp_valid[i]; it must drop the request no later than
// the cycle after resp_valid[i]. That one trailing cycle is masked so the
// stale request is not granted again; a request still high after it is a new
// request. req_valid/req_page are only looked at in IDLE.
// -----------------------------------------------------------------------------
module pagerank_noc_arbiter #(
    parameter int ANTS  = 4,
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int PW    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ANTS-1:0]       req_valid,
    input  logic [ANTS*PW-1:0]    req_page,
    output logic [PW-1:0]         query,
    output logic [ANTS-1:0]       query_valid,
    input  logic [ANTS*WIDTH-1:0] reply_in,
    output logic [WIDTH+PW-1:0]   response,
    output logic [ANTS-1:0]       resp_valid,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           xfer_count,
    output logic [1:0]            dbg_state
);

    localparam int AW = (ANTS > 1) ? $clog2(ANTS) : 1;
    localparam int NB = $clog2(N);
    // One bit wider than a page id so ANTS*N == 2^PW is representable.
    localparam logic [PW:0] PAGE_LIMIT = (PW+1)'(ANTS * N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_REPLY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          grant_q, grant_d;
    logic [PW-1:0]          page_q, page_d;
    logic [AW-1:0]          owner_q, owner_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW-1:0]          last_grant_q, last_grant_d;
    logic                   hold_mask_q, hold_mask_d;
    logic                   err_q, err_d;
    logic [WIDTH+PW-1:0]    response_q, response_d;
    logic [15:0]            xfer_q, xfer_d;

    logic [ANTS-1:0]        masked_req;
    logic                   found;
    logic [AW-1:0]          pick;
    logic [AW-1:0]          cand;
    logic [PW-1:0]          sel_page;
    logic                   out_of_range;

    assign out_of_range = ({1'b0, page_q} >= PAGE_LIMIT);

    // Round-robin search starting at ptr; AW-bit addition wraps modulo ANTS
    // because ANTS is a power of two.
    always_comb begin
        masked_req = req_valid;
        if (hold_mask_q) begin
            masked_req[last_grant_q] = 1'b0;
        end
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < ANTS; i++) begin
            cand = ptr_q + AW'(i);
            if (!found && masked_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel_page = req_page[pick*PW +: PW];
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        page_d       = page_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        hold_mask_d  = hold_mask_q;
        err_d        = err_q;
        response_d   = response_q;
        xfer_d       = xfer_q;

        case (state_q)
            S_IDLE: begin
                // The stale-request mask only ever covers one IDLE cycle.
                hold_mask_d = 1'b0;
                if (found) begin
                    grant_d = pick;
                    page_d  = sel_page;
                    owner_d = sel_page[NB +: AW];
                    state_d = S_QUERY;
                end
            end
            S_QUERY: begin
                if (out_of_range) begin
                    err_d = 1'b1;
                end
                state_d = S_REPLY;
            end
            S_REPLY: begin
                // Capture straight into the response register so it holds
                // after RESP without a separate data register.
                response_d = {(out_of_range ? WIDTH'(0)
                                            : reply_in[owner_q*WIDTH +: WIDTH]),
                              page_q};
                state_d    = S_RESP;
            end
            S_RESP: begin
                ptr_d        = grant_q + AW'(1);
                last_grant_d = grant_q;
                hold_mask_d  = 1'b1;
                xfer_d       = xfer_q + 16'd1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            page_q       <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            last_grant_q <= '0;
            hold_mask_q  <= 1'b0;
            err_q        <= 1'b0;
            response_q   <= '0;
            xfer_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            page_q       <= page_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            hold_mask_q  <= hold_mask_d;
            err_q        <= err_d;
            response_q   <= response_d;
            xfer_q       <= xfer_d;
        end
    end

    // Outputs decode from registered state and latched fields only.
    always_comb begin
        query       = '0;
        query_valid = '0;
        resp_valid  = '0;
        if (state_q == S_QUERY || state_q == S_REPLY) begin
            query = page_q;
            if (!out_of_range) begin
                query_valid = ANTS'(1) << owner_q;
            end
        end
        if (state_q == S_RESP) begin
            resp_valid = ANTS'(1) << grant_q;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign response   = response_q;
    assign xfer_count = xfer_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pagerank_noc_arbiter.sv
module tb_pagerank_noc_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // Four-ant instance
    logic [3:0]  req_valid;
    logic [23:0] req_page;
    logic [5:0]  query;
    logic [3:0]  query_valid;
    logic [63:0] reply_in;
    logic [21:0] response;
    logic [3:0]  resp_valid;
    logic        busy;
    logic        err;
    logic [15:0] xfer_count;
    logic [1:0]  dbg_state;

    // Two-ant instance, used for the out-of-range page case
    logic [1:0]  req_valid2;
    logic [11:0] req_page2;
    logic [5:0]  query2;
    logic [1:0]  query_valid2;
    logic [31:0] reply_in2;
    logic [21:0] response2;
    logic [1:0]  resp_valid2;
    logic        busy2;
    logic        err2;
    logic [15:0] xfer_count2;
    logic [1:0]  dbg_state2;

    int errors = 0;
    int checks = 0;
    int exp_xfer = 0;

    pagerank_noc_arbiter #(.ANTS(4), .N(16), .WIDTH(16), .PW(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_page(req_page),
        .query(query), .query_valid(query_valid),
        .reply_in(reply_in), .response(response), .resp_valid(resp_valid),
        .busy(busy), .err(err), .xfer_count(xfer_count), .dbg_state(dbg_state)
    );

    pagerank_noc_arbiter #(.ANTS(2), .N(16), .WIDTH(16), .PW(6)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_page(req_page2),
        .query(query2), .query_valid(query_valid2),
        .reply_in(reply_in2), .response(response2), .resp_valid(resp_valid2),
        .busy(busy2), .err(err2), .xfer_count(xfer_count2), .dbg_state(dbg_state2)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic [23:0] pages;
        logic [63:0] replies;
        logic [3:0]  exp_qv;
        logic [5:0]  exp_q;
        logic [3:0]  exp_rv;
        logic [21:0] exp_resp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        req_valid2 = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [5:0]  cont_page[4];
    logic [21:0] cont_resp[4];

    initial begin
        req_page   = '0;
        reply_in   = '0;
        req_page2  = '0;
        reply_in2  = '0;

        vecs[0] = '{4'b0010, {6'd0, 6'd0, 6'd37, 6'd0},
                    {16'h3333, 16'h1234, 16'h1111, 16'h0000},
                    4'b0100, 6'd37, 4'b0010, {16'h1234, 6'd37}};
        vecs[1] = '{4'b0100, {6'd0, 6'd40, 6'd0, 6'd0},
                    {16'hAAAA, 16'hBEEF, 16'hCCCC, 16'hDDDD},
                    4'b0100, 6'd40, 4'b0100, {16'hBEEF, 6'd40}};
        vecs[2] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd5},
                    {16'h4444, 16'h3333, 16'h2222, 16'h0A0A},
                    4'b0001, 6'd5, 4'b0001, {16'h0A0A, 6'd5}};
        vecs[3] = '{4'b1000, {6'd63, 6'd0, 6'd0, 6'd0},
                    {16'hFFFF, 16'h0102, 16'h0304, 16'h0506},
                    4'b1000, 6'd63, 4'b1000, {16'hFFFF, 6'd63}};
        vecs[4] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd20},
                    {16'h7777, 16'h6666, 16'h5555, 16'h8888},
                    4'b0010, 6'd20, 4'b0001, {16'h5555, 6'd20}};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_query", 64'(query), 64'd0);
        chk("rst_query_valid", 64'(query_valid), 64'd0);
        chk("rst_response", 64'(response), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_xfer", 64'(xfer_count), 64'd0);

        // ---------------- single-request vectors ----------------
        for (int v = 0; v < 5; v++) begin
            req_valid = vecs[v].rv;
            req_page  = vecs[v].pages;
            reply_in  = vecs[v].replies;
            tick();
            chk($sformatf("v%0d_qv_t1", v), 64'(query_valid), 64'(vecs[v].exp_qv));
            chk($sformatf("v%0d_q_t1", v), 64'(query), 64'(vecs[v].exp_q));
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
            chk($sformatf("v%0d_rv_t1", v), 64'(resp_valid), 64'd0);
            tick();
            chk($sformatf("v%0d_qv_t2", v), 64'(query_valid), 64'(vecs[v].exp_qv));
            chk($sformatf("v%0d_q_t2", v), 64'(query), 64'(vecs[v].exp_q));
            chk($sformatf("v%0d_state_t2", v), 64'(dbg_state), 64'd2);
            tick();
            chk($sformatf("v%0d_rv_t3", v), 64'(resp_valid), 64'(vecs[v].exp_rv));
            chk($sformatf("v%0d_resp_t3", v), 64'(response), 64'(vecs[v].exp_resp));
            chk($sformatf("v%0d_qv_t3", v), 64'(query_valid), 64'd0);
            req_valid = '0;
            tick();
            exp_xfer++;
            chk($sformatf("v%0d_xfer", v), 64'(xfer_count), 64'(exp_xfer));
            chk($sformatf("v%0d_rv_t4", v), 64'(resp_valid), 64'd0);
            chk($sformatf("v%0d_resp_hold", v), 64'(response), 64'(vecs[v].exp_resp));
            tick();
        end
        chk("err_in_range", 64'(err), 64'd0);

        // ---------------- contention: all four at once ----------------
        cont_page[0] = 6'd50; cont_page[1] = 6'd9; cont_page[2] = 6'd30; cont_page[3] = 6'd45;
        reply_in = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        cont_resp[0] = {16'hC003, 6'd50};
        cont_resp[1] = {16'hC000, 6'd9};
        cont_resp[2] = {16'hC001, 6'd30};
        cont_resp[3] = {16'hC002, 6'd45};
        do_reset();
        req_page  = {cont_page[3], cont_page[2], cont_page[1], cont_page[0]};
        req_valid = 4'b1111;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c % 4 == 3) begin
                chk($sformatf("cont_rv_c%0d", c), 64'(resp_valid), 64'(4'b0001 << (c / 4)));
                chk($sformatf("cont_resp_c%0d", c), 64'(response), 64'(cont_resp[c / 4]));
                req_valid[c / 4] = 1'b0;
            end else begin
                chk($sformatf("cont_rv_c%0d", c), 64'(resp_valid), 64'd0);
            end
        end
        // ptr has wrapped to 0: ant 0 wins over ant 3
        req_valid = 4'b1001;
        tick();
        chk("wrap_qv", 64'(query_valid), 64'(4'b1000));
        chk("wrap_q", 64'(query), 64'd50);
        tick();
        tick();
        chk("wrap_rv", 64'(resp_valid), 64'(4'b0001));
        req_valid = '0;
        tick();
        chk("wrap_xfer", 64'(xfer_count), 64'd5);
        tick();

        // ---------------- stale request mask ----------------
        do_reset();
        req_page  = {6'd33, 6'd0, 6'd0, 6'd12};
        reply_in  = {16'h0303, 16'h0202, 16'h0101, 16'h0F0F};
        req_valid = 4'b0001;
        tick(); tick(); tick();
        chk("stale_rv0", 64'(resp_valid), 64'(4'b0001));
        chk("stale_resp0", 64'(response), 64'({16'h0F0F, 6'd12}));
        tick();                        // IDLE with ant 0 still requesting
        tick();
        chk("stale_busy", 64'(busy), 64'd0);
        chk("stale_rv_none", 64'(resp_valid), 64'd0);
        req_valid = 4'b1000;
        tick();
        chk("stale_qv3", 64'(query_valid), 64'(4'b0100));
        chk("stale_q3", 64'(query), 64'd33);
        tick(); tick();
        chk("stale_rv3", 64'(resp_valid), 64'(4'b1000));
        chk("stale_resp3", 64'(response), 64'({16'h0202, 6'd33}));
        req_valid = '0;
        tick(); tick();

        // ---------------- mid-transaction reset ----------------
        req_page  = {6'd0, 6'd0, 6'd37, 6'd0};
        reply_in  = {16'h3333, 16'h1234, 16'h1111, 16'h0000};
        req_valid = 4'b0010;
        tick();
        chk("mid_qv", 64'(query_valid), 64'(4'b0100));
        tick();                        // REPLY
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
        chk("mid_query", 64'(query), 64'd0);
        chk("mid_qv_zero", 64'(query_valid), 64'd0);
        chk("mid_response", 64'(response), 64'd0);
        chk("mid_rv", 64'(resp_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_xfer", 64'(xfer_count), 64'd0);
        tick();
        chk("mid_rv_after", 64'(resp_valid), 64'd0);
        req_valid = 4'b0010;
        tick(); tick(); tick();
        chk("mid_redo_rv", 64'(resp_valid), 64'(4'b0010));
        chk("mid_redo_resp", 64'(response), 64'({16'h1234, 6'd37}));
        req_valid = '0;
        tick();
        chk("mid_redo_xfer", 64'(xfer_count), 64'd1);
        tick();

        // ---------------- out-of-range page on the two-ant instance ----------------
        chk("oor_err_before", 64'(err2), 64'd0);
        req_page2  = {6'd40, 6'd0};
        reply_in2  = {16'hABCD, 16'h9999};
        req_valid2 = 2'b10;
        tick();
        chk("oor_qv_t1", 64'(query_valid2), 64'd0);
        chk("oor_busy", 64'(busy2), 64'd1);
        tick();
        chk("oor_qv_t2", 64'(query_valid2), 64'd0);
        chk("oor_err", 64'(err2), 64'd1);
        tick();
        chk("oor_rv", 64'(resp_valid2), 64'(2'b10));
        chk("oor_resp", 64'(response2), 64'({16'h0000, 6'd40}));
        req_valid2 = '0;
        tick();
        chk("oor_xfer", 64'(xfer_count2), 64'd1);
        tick();
        // in range afterwards: err stays set
        req_page2  = {6'd0, 6'd17};
        req_valid2 = 2'b01;
        tick();
        chk("oor2_qv", 64'(query_valid2), 64'(2'b10));
        tick(); tick();
        chk("oor2_rv", 64'(resp_valid2), 64'(2'b01));
        chk("oor2_resp", 64'(response2), 64'({16'hABCD, 6'd17}));
        req_valid2 = '0;
        tick();
        chk("oor2_err_sticky", 64'(err2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
